// File: rtl/fmaalignpipe.sv
// fmaalignpipe: FMA addend alignment control, two register stages.
// Build option FMA_ALIGN_SAT_EN clamps ACnt to [0, 3NF+4].
module fmaalignpipe #(
    parameter int NE   = 11,
    parameter int NF   = 52,
    parameter int BIAS = 2**(NE-1)-1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          Flush,
    input  logic          InValid,
    output logic          InReady,
    input  logic [NE+1:0] Pe,
    input  logic [NE-1:0] Ze,
    input  logic          XZero,
    input  logic          YZero,
    input  logic          ZZero,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [NE+2:0] ACnt,
    output logic          KillProd,
    output logic          KillZ,
    output logic [NE+1:0] Se
);

    localparam int W = NE + 3;
    localparam logic signed [W-1:0] KZLIM  = W'(3*NF+3);
    localparam logic signed [W-1:0] SATMAX = W'(3*NF+4);
    localparam logic [W-1:0]        ADDK   = W'(NF+2);

    typedef struct packed {
        logic [W-1:0]  raw;
        logic [NE+1:0] pe;
        logic [NE-1:0] ze;
        logic          xz;
        logic          yz;
        logic          zz;
    } s1_t;

    s1_t           s1_d;
    s1_t           s1_q;
    logic          v1;
    logic          v2;
    logic          en1;
    logic          en2;
    logic [W-1:0]  acnt_d;
    logic          kp_d;
    logic          kz_d;
    logic [NE+1:0] se_d;

    assign en2      = ~v2 | OutReady;
    assign en1      = ~v1 | en2;
    assign InReady  = en1;
    assign OutValid = v2;

    // S1 input: raw shift count from the sign-extended product exponent
    always_comb begin
        s1_d     = '0;
        s1_d.raw = {Pe[NE+1], Pe} - {3'b000, Ze} + ADDK;
        s1_d.pe  = Pe;
        s1_d.ze  = Ze;
        s1_d.xz  = XZero;
        s1_d.yz  = YZero;
        s1_d.zz  = ZZero;
    end

    // S2 input: kill decisions, sum exponent and (optionally clamped) count
    always_comb begin
        kp_d   = (s1_q.raw[W-1] & ~s1_q.zz) | s1_q.xz | s1_q.yz;
        kz_d   = (($signed(s1_q.raw) > KZLIM) & ~s1_q.xz & ~s1_q.yz)
                 | s1_q.zz;
        se_d   = kp_d ? {2'b00, s1_q.ze} : s1_q.pe;
        acnt_d = s1_q.raw;
`ifdef FMA_ALIGN_SAT_EN
        if (s1_q.raw[W-1]) begin
            acnt_d = '0;
        end else if ($signed(s1_q.raw) > SATMAX) begin
            acnt_d = SATMAX;
        end
`endif
    end

    // Stage valid bits; flush empties both stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (Flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (en1) v1 <= InValid;
            if (en2) v2 <= v1;
        end
    end

    // S1 data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
        end else if (en1) begin
            s1_q <= s1_d;
        end
    end

    // S2 data register driving the outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ACnt     <= '0;
            KillProd <= 1'b0;
            KillZ    <= 1'b0;
            Se       <= '0;
        end else if (en2) begin
            ACnt     <= acnt_d;
            KillProd <= kp_d;
            KillZ    <= kz_d;
            Se       <= se_d;
        end
    end

endmodule
